// File: rtl/sd_block_mgr_if.sv
// Purpose: bundles the sd_link block-transfer signals and the host request/ack channel of sd_block_mgr.
// Latency: none (wiring only).
// Backpressure: host_req is held until host_ack; the link side sees go/done pulses.
interface sd_block_mgr_if;
    // sd_link side
    logic        block_read_act;
    logic [31:0] block_read_addr;
    logic [31:0] block_read_num;
    logic        block_read_stop;
    logic        block_write_act;
    logic [31:0] block_write_addr;
    logic [31:0] block_write_num;
    logic        block_read_go;
    logic        block_write_done;
    // host side
    logic        host_req;
    logic        host_req_write;
    logic [31:0] host_req_addr;
    logic        host_ack;
    // status
    logic        busy;
    logic        err_timeout;
    logic        err_clear;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    // The block manager itself
    modport master (
        input  block_read_act, block_read_addr, block_read_num, block_read_stop,
        input  block_write_act, block_write_addr, block_write_num,
        input  host_ack, err_clear,
        output block_read_go, block_write_done,
        output host_req, host_req_write, host_req_addr,
        output busy, err_timeout, rd_count, wr_count
    );

    // The surrounding sd_link / host environment
    modport slave (
        output block_read_act, block_read_addr, block_read_num, block_read_stop,
        output block_write_act, block_write_addr, block_write_num,
        output host_ack, err_clear,
        input  block_read_go, block_write_done,
        input  host_req, host_req_write, host_req_addr,
        input  busy, err_timeout, rd_count, wr_count
    );
endinterface

// File: rtl/sd_block_mgr.sv
// Purpose: turns sd_link block read/write activity into single-block host requests and returns go/done pulses.
// Latency: request edge -> host_req next cycle; host_ack -> go/done next cycle for PULSE_CYCLES cycles.
// Backpressure: host_req held until host_ack or timeout; new link requests wait (stay pending) until IDLE.
module sd_block_mgr #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000,
    parameter int          PULSE_CYCLES   = 2
) (
    input  logic          clk_50,
    input  logic          reset_n,
    sd_block_mgr_if.master bus
);

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        WR_REQ  = 3'd2,
        RD_GO   = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    state_t      state;
    logic [23:0] tcnt;
    logic [3:0]  pcnt;
    logic        stop_flag;

    // Registered copies of the link levels. The arm bits stay low after reset
    // until the matching act has been seen low, so an act already high when
    // reset is released is not mistaken for a fresh request.
    logic        rd_act_q, wr_act_q;
    logic        rd_arm, wr_arm;
    logic [31:0] rd_num_q, wr_num_q;

    logic rd_new, wr_new, rd_take, wr_take, to_hit;

    // Request detection and arbitration: read wins a same-cycle tie.
    always_comb begin
        rd_new  = rd_arm & bus.block_read_act &
                  (~rd_act_q | (bus.block_read_num != rd_num_q));
        wr_new  = wr_arm & bus.block_write_act &
                  (~wr_act_q | (bus.block_write_num != wr_num_q));
        rd_take = (state == IDLE) & rd_new;
        wr_take = (state == IDLE) & wr_new & ~rd_new;
        to_hit  = (TIMEOUT_CYCLES != 24'd0) && (tcnt == TIMEOUT_CYCLES);
    end

    // Link level copies; a detected but not-yet-accepted request keeps its old copy so IDLE sees it again.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            rd_act_q <= 1'b0;
            wr_act_q <= 1'b0;
            rd_arm   <= 1'b0;
            wr_arm   <= 1'b0;
            rd_num_q <= 32'd0;
            wr_num_q <= 32'd0;
        end else begin
            rd_arm <= rd_arm | ~bus.block_read_act;
            wr_arm <= wr_arm | ~bus.block_write_act;
            if (!rd_new || rd_take) begin
                rd_act_q <= bus.block_read_act;
                rd_num_q <= bus.block_read_num;
            end
            if (!wr_new || wr_take) begin
                wr_act_q <= bus.block_write_act;
                wr_num_q <= bus.block_write_num;
            end
        end
    end

    // Transfer sequencer with registered outputs, timeout and statistics.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            tcnt                 <= 24'd0;
            pcnt                 <= 4'd0;
            stop_flag            <= 1'b0;
            bus.host_req         <= 1'b0;
            bus.host_req_write   <= 1'b0;
            bus.host_req_addr    <= 32'd0;
            bus.block_read_go    <= 1'b0;
            bus.block_write_done <= 1'b0;
            bus.busy             <= 1'b0;
            bus.err_timeout      <= 1'b0;
            bus.rd_count         <= 16'd0;
            bus.wr_count         <= 16'd0;
        end else begin
            // A timeout in the same cycle overrides the clear further down.
            if (bus.err_clear)
                bus.err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (rd_take) begin
                        state              <= RD_REQ;
                        bus.host_req       <= 1'b1;
                        bus.host_req_write <= 1'b0;
                        bus.host_req_addr  <= bus.block_read_addr + bus.block_read_num;
                        bus.busy           <= 1'b1;
                        stop_flag          <= 1'b0;
                        tcnt               <= 24'd1;
                    end else if (wr_take) begin
                        state              <= WR_REQ;
                        bus.host_req       <= 1'b1;
                        bus.host_req_write <= 1'b1;
                        bus.host_req_addr  <= bus.block_write_addr + bus.block_write_num;
                        bus.busy           <= 1'b1;
                        stop_flag          <= 1'b0;
                        tcnt               <= 24'd1;
                    end
                end

                RD_REQ, WR_REQ: begin
                    if (bus.host_ack) begin
                        bus.host_req <= 1'b0;
                        if (state == WR_REQ) begin
                            state                <= WR_DONE;
                            bus.block_write_done <= 1'b1;
                            pcnt                 <= 4'd1;
                            bus.wr_count         <= bus.wr_count + 16'd1;
                        end else if (stop_flag) begin
                            // Aborted read: finish quietly, nothing counted.
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state             <= RD_GO;
                            bus.block_read_go <= 1'b1;
                            pcnt              <= 4'd1;
                            bus.rd_count      <= bus.rd_count + 16'd1;
                        end
                    end else if (to_hit) begin
                        state           <= IDLE;
                        bus.host_req    <= 1'b0;
                        bus.busy        <= 1'b0;
                        bus.err_timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 24'd1;
                        if (state == RD_REQ && bus.block_read_stop)
                            stop_flag <= 1'b1;
                    end
                end

                RD_GO, WR_DONE: begin
                    if (pcnt == PULSE_LAST) begin
                        state                <= IDLE;
                        bus.block_read_go    <= 1'b0;
                        bus.block_write_done <= 1'b0;
                        bus.busy             <= 1'b0;
                    end else begin
                        pcnt <= pcnt + 4'd1;
                    end
                end

                default: begin
                    state                <= IDLE;
                    bus.host_req         <= 1'b0;
                    bus.block_read_go    <= 1'b0;
                    bus.block_write_done <= 1'b0;
                    bus.busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_mgr.sv
// Purpose: directed bench for sd_block_mgr (vector table plus hand-written corner sequences).
// Latency: checks request, ack-to-pulse and timeout cycle counts against hand-computed values.
// Backpressure: host_ack is driven by the bench with chosen delays.
module tb_sd_block_mgr;

    logic clk_50  = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk_50 = ~clk_50;

    sd_block_mgr_if bus();

    sd_block_mgr #(
        .TIMEOUT_CYCLES(24'd50),
        .PULSE_CYCLES  (2)
    ) dut (
        .clk_50 (clk_50),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_rd   = 0;
    int exp_wr   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] num;
        int          ack_dly;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Ticks n cycles and reports whether any go/done pulse was seen.
    task automatic watch(input int n, output logic any_pulse);
        any_pulse = 1'b0;
        repeat (n) begin
            tick;
            any_pulse = any_pulse | bus.block_read_go | bus.block_write_done;
        end
    endtask

    // Request inputs are already set up; runs one full request/ack/pulse cycle.
    task automatic run_req(input logic wr, input logic [31:0] exp_addr, input int ack_dly, input string tag);
        int   w;
        logic other;
        logic held;
        tick;
        check({tag, " host_req"}, 32'(bus.host_req), 32'd1);
        check({tag, " host_req_write"}, 32'(bus.host_req_write), 32'(wr));
        check({tag, " host_req_addr"}, bus.host_req_addr, exp_addr);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        held = 1'b1;
        repeat (ack_dly) begin
            tick;
            held = held & bus.host_req;
        end
        check({tag, " host_req held"}, 32'(held), 32'd1);
        bus.host_ack = 1'b1;
        tick;
        bus.host_ack = 1'b0;
        check({tag, " host_req after ack"}, 32'(bus.host_req), 32'd0);
        w     = 0;
        other = 1'b0;
        while ((wr ? bus.block_write_done : bus.block_read_go) && w < 20) begin
            w++;
            other = other | (wr ? bus.block_read_go : bus.block_write_done);
            tick;
        end
        check({tag, " pulse width"}, 32'(w), 32'd2);
        check({tag, " other pulse"}, 32'(other), 32'd0);
        check({tag, " busy after pulse"}, 32'(bus.busy), 32'd0);
        if (wr) exp_wr++;
        else    exp_rd++;
        check({tag, " rd_count"}, 32'(bus.rd_count), 32'(exp_rd[15:0]));
        check({tag, " wr_count"}, 32'(bus.wr_count), 32'(exp_wr[15:0]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic any;

        vecs[0] = '{1'b0, 32'h0000_003F, 32'h0000_0000, 10, 32'h0000_003F};
        vecs[1] = '{1'b1, 32'h0000_003F, 32'h0000_0000, 3,  32'h0000_003F};
        vecs[2] = '{1'b0, 32'h0000_1000, 32'h0000_0005, 0,  32'h0000_1005};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1,  32'h0000_0001};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2,  32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 32'h1234_5678, 32'h0000_0010, 5,  32'h1234_5688};

        bus.block_read_act   = 1'b0;
        bus.block_read_addr  = 32'd0;
        bus.block_read_num   = 32'd0;
        bus.block_read_stop  = 1'b0;
        bus.block_write_act  = 1'b0;
        bus.block_write_addr = 32'd0;
        bus.block_write_num  = 32'd0;
        bus.host_ack         = 1'b0;
        bus.err_clear        = 1'b0;

        // Reset state
        #12;
        check("reset host_req", 32'(bus.host_req), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset pulses", 32'({bus.block_read_go, bus.block_write_done}), 32'd0);
        check("reset err_timeout", 32'(bus.err_timeout), 32'd0);
        check("reset counts", {bus.rd_count, bus.wr_count}, 32'd0);
        tick;
        reset_n = 1'b1;
        repeat (3) tick;

        // Vector table: single reads and writes, address arithmetic incl. wrap
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr) begin
                bus.block_write_addr = vecs[i].addr;
                bus.block_write_num  = vecs[i].num;
                bus.block_write_act  = 1'b1;
            end else begin
                bus.block_read_addr = vecs[i].addr;
                bus.block_read_num  = vecs[i].num;
                bus.block_read_act  = 1'b1;
            end
            run_req(vecs[i].wr, vecs[i].exp_addr, vecs[i].ack_dly, $sformatf("vec%0d", i));
            bus.block_read_act  = 1'b0;
            bus.block_write_act = 1'b0;
            tick;
            tick;
        end

        // Multi-block read: act held, num steps after each go
        bus.block_read_addr = 32'h100;
        bus.block_read_num  = 32'd0;
        bus.block_read_act  = 1'b1;
        run_req(1'b0, 32'h100, 4, "mb0");
        bus.block_read_num = 32'd1;
        run_req(1'b0, 32'h101, 2, "mb1");
        bus.block_read_num = 32'd2;
        run_req(1'b0, 32'h102, 1, "mb2");
        bus.block_read_act = 1'b0;
        tick;
        tick;

        // Stop during RD_REQ, then ack: no go, no count, busy drops at once
        bus.block_read_addr = 32'h200;
        bus.block_read_num  = 32'd0;
        bus.block_read_act  = 1'b1;
        tick;
        check("stop host_req", 32'(bus.host_req), 32'd1);
        tick;
        bus.block_read_stop = 1'b1;
        tick;
        bus.block_read_stop = 1'b0;
        tick;
        check("stop host_req kept", 32'(bus.host_req), 32'd1);
        tick;
        bus.host_ack = 1'b1;
        tick;
        bus.host_ack = 1'b0;
        check("stop busy after ack", 32'(bus.busy), 32'd0);
        check("stop go after ack", 32'(bus.block_read_go), 32'd0);
        watch(5, any);
        check("stop no pulse", 32'(any), 32'd0);
        check("stop rd_count", 32'(bus.rd_count), 32'(exp_rd[15:0]));
        bus.block_read_act = 1'b0;
        tick;
        tick;

        // Timeout: host_req high for exactly 50 cycles, sticky error, no pulse
        bus.block_read_addr = 32'h300;
        bus.block_read_num  = 32'd0;
        bus.block_read_act  = 1'b1;
        tick;
        n   = 0;
        any = 1'b0;
        while (bus.host_req && n < 200) begin
            n++;
            any = any | bus.block_read_go | bus.block_write_done;
            tick;
        end
        check("timeout host_req cycles", 32'(n), 32'd50);
        check("timeout err_timeout", 32'(bus.err_timeout), 32'd1);
        check("timeout busy", 32'(bus.busy), 32'd0);
        check("timeout no pulse", 32'(any), 32'd0);
        bus.host_ack = 1'b1;
        tick;
        bus.host_ack = 1'b0;
        watch(3, any);
        check("late ack ignored pulse", 32'(any), 32'd0);
        check("late ack ignored count", 32'(bus.rd_count), 32'(exp_rd[15:0]));
        bus.block_read_act = 1'b0;
        tick;
        check("err_timeout sticky", 32'(bus.err_timeout), 32'd1);
        bus.err_clear = 1'b1;
        tick;
        bus.err_clear = 1'b0;
        check("err_clear", 32'(bus.err_timeout), 32'd0);
        bus.block_read_num = 32'd1;
        bus.block_read_act = 1'b1;
        run_req(1'b0, 32'h301, 2, "after timeout");
        bus.block_read_act = 1'b0;
        tick;
        tick;

        // Ack in the very cycle the count reaches the limit wins over timeout
        bus.block_read_addr = 32'h380;
        bus.block_read_num  = 32'd0;
        bus.block_read_act  = 1'b1;
        run_req(1'b0, 32'h380, 49, "ack at limit");
        check("ack at limit no error", 32'(bus.err_timeout), 32'd0);
        bus.block_read_act = 1'b0;
        tick;
        tick;

        // Read and write in the same cycle: read first, write follows
        bus.block_read_addr  = 32'h400;
        bus.block_read_num   = 32'd0;
        bus.block_write_addr = 32'h500;
        bus.block_write_num  = 32'd3;
        bus.block_read_act   = 1'b1;
        bus.block_write_act  = 1'b1;
        run_req(1'b0, 32'h400, 2, "tie read");
        run_req(1'b1, 32'h503, 2, "tie write");
        bus.block_read_act  = 1'b0;
        bus.block_write_act = 1'b0;
        tick;
        tick;

        // Stray ack in IDLE
        bus.host_ack = 1'b1;
        tick;
        bus.host_ack = 1'b0;
        watch(3, any);
        check("idle ack no pulse", 32'(any), 32'd0);
        check("idle ack busy", 32'(bus.busy), 32'd0);
        check("idle ack counts", {bus.rd_count, bus.wr_count}, {exp_rd[15:0], exp_wr[15:0]});

        // Asynchronous reset during WR_REQ, act left high across release
        bus.block_write_addr = 32'h600;
        bus.block_write_num  = 32'd0;
        bus.block_write_act  = 1'b1;
        tick;
        check("pre-reset host_req", 32'(bus.host_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset host_req", 32'(bus.host_req), 32'd0);
        check("async reset busy", 32'(bus.busy), 32'd0);
        check("async reset req fields", bus.host_req_addr | 32'(bus.host_req_write), 32'd0);
        check("async reset counts", {bus.rd_count, bus.wr_count}, 32'd0);
        exp_rd = 0;
        exp_wr = 0;
        tick;
        tick;
        reset_n = 1'b1;
        n = 0;
        repeat (5) begin
            tick;
            if (bus.host_req || bus.busy || bus.block_write_done) n++;
        end
        check("no request with act held", 32'(n), 32'd0);
        bus.block_write_act = 1'b0;
        tick;
        tick;
        bus.block_write_act = 1'b1;
        run_req(1'b1, 32'h600, 3, "post reset");
        bus.block_write_act = 1'b0;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_block_mgr.md
# sd_block_mgr

- Sequences block transfers between `sd_link` and the host-side storage agent (CPU/DMA) that fills the read buffer and drains the write buffer.
- Detects block read/write requests from `sd_link` and forwards each as a single-block request to the host.
- Returns `block_read_go` or `block_write_done` pulses to `sd_link`, and handles stop, timeout and statistics.
- Replaces the ad-hoc manager logic around `sd_link`; sits in the `clk_50` domain next to `sd_link`.

## Interface
Parameters:
- TIMEOUT_CYCLES, 24'd5000000: host-ack timeout in `clk_50` cycles; 0 disables the timeout.
- PULSE_CYCLES, 2: width of the `block_read_go` / `block_write_done` pulse; legal range 1–15.

Ports:
- clk_50  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- block_read_act  in  1  from `sd_link`; level, high while a read command is active.
- block_read_addr  in  32  from `sd_link`; block address of the current read.
- block_read_num  in  32  from `sd_link`; index of the block within a multi-block read.
- block_read_stop  in  1  from `sd_link`; the host aborted the read.
- block_write_act  in  1  from `sd_link`; level, high while the write buffer holds a received block.
- block_write_addr  in  32  from `sd_link`; block address of the current write.
- block_write_num  in  32  from `sd_link`; index of the block within a multi-block write.
- block_read_go  out  1  to `sd_link`; the read buffer is valid.
- block_write_done  out  1  to `sd_link`; the write buffer has been consumed.
- host_req  out  1  request to the host, held until acknowledged.
- host_req_write  out  1  1 = write request, 0 = read request; valid while `host_req` is high.
- host_req_addr  out  32  block address (`block_*_addr` + `block_*_num`); valid while `host_req` is high.
- host_ack  in  1  one-cycle pulse from the host: request complete.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky; cleared by `err_clear`.
- err_clear  in  1  one-cycle pulse that clears `err_timeout`.
- rd_count  out  16  completed read blocks; wraps.
- wr_count  out  16  completed write blocks; wraps.

## Operation
- Request detection uses registered copies of `block_read_act`, `block_write_act`, `block_read_num` and `block_write_num`. A new request is either:
  - a rising edge of `*_act`, or
  - a change of `*_num` while `*_act` is high.
- Requests are detected only in IDLE. If read and write are detected in the same cycle, read wins; the write stays pending because its `*_act` level is still high and it is re-detected in IDLE.
- IDLE -> RD_REQ on a read request:
  - latch `host_req_addr` = `block_read_addr` + `block_read_num` (32-bit, wraps);
  - `host_req_write` = 0; clear the stop flag.
- IDLE -> WR_REQ on a write request: same, using the write address and `host_req_write` = 1.
- RD_REQ / WR_REQ:
  - `host_req` is high; the timeout counter increments every cycle.
  - In RD_REQ, `block_read_stop` sets the internal stop flag; `host_req` is not withdrawn.
- On `host_ack`:
  - RD_REQ -> RD_GO, or -> IDLE without a pulse and without counting if the stop flag is set;
  - WR_REQ -> WR_DONE.
- When the counter reaches TIMEOUT_CYCLES with no ack:
  - set `err_timeout`, drop `host_req`, go to IDLE;
  - no go/done pulse and no count increment.
- RD_GO: `block_read_go` is high for PULSE_CYCLES, then IDLE. `rd_count` increments once on entry.
- WR_DONE: `block_write_done` is high for PULSE_CYCLES, then IDLE. `wr_count` increments once on entry.
- If `err_clear` and a timeout occur in the same cycle, the set wins.
- A `host_ack` seen in IDLE, RD_GO or WR_DONE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, registered input copies 0. Reset takes effect immediately (asynchronously), even mid-transfer; no pulse is emitted afterwards.
- Edge at cycle N (`*_act` high, registered copy low) -> `host_req` high at N+1.
- `host_ack` sampled at cycle M -> `host_req` low at M+1. `block_read_go` / `block_write_done` is high for cycles M+1 .. M+PULSE_CYCLES and `busy` falls at M+PULSE_CYCLES+1.
- Timeout:
  - first REQ cycle = count 1; at count TIMEOUT_CYCLES, `host_req` falls and `err_timeout` rises on the next edge;
  - an ack in that same cycle takes priority (no timeout).
- A new request is accepted no earlier than the cycle after returning to IDLE.

## Test plan
- Single read: `block_read_act` rises with addr=0x3F, num=0; ack 10 cycles later -> `host_req_addr`=0x3F, `host_req_write`=0, `block_read_go` high exactly 2 cycles, `rd_count`=1.
- Single write: `block_write_act` rises with addr=0x3F; ack -> `host_req_write`=1, `block_write_done` 2-cycle pulse, `wr_count`=1, no read pulse.
- Multi-block read: act held high, num steps 0→1→2 after each go -> three requests with addresses 0x100, 0x101, 0x102, `rd_count`=3.
- Stop: `block_read_stop` pulses during RD_REQ, then ack -> no `block_read_go`, `rd_count` unchanged, `busy` low the next cycle.
- Timeout with TIMEOUT_CYCLES=50 and no ack -> `host_req` falls after 50 cycles, `err_timeout`=1 until `err_clear`, no pulse; a following read then completes normally.
- `reset_n` asserted during WR_REQ -> all outputs 0 asynchronously; after release with act still high, no request until act falls and rises again.
